// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the ID-stage forwarding / hazard unit.
// Holds the default datapath widths, the zero-register address, the
// enable polarities, the hazard FSM state encoding and the forward
// source encoding used by the per-port priority mux.
package fwd_hazard_unit_pkg;

    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;

    // x0 is hardwired to zero: it is never forwarded and never busy.
    localparam logic [RADDR_WIDTH-1:0] ZERO = '0;

    localparam logic READ_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        FH_RUN  = 2'd0,
        FH_LOAD = 2'd1,
        FH_LAT  = 2'd2
    } fh_state_e;

    typedef enum logic [2:0] {
        FW_NONE = 3'd0,
        FW_EXE  = 3'd1,
        FW_MEM  = 3'd2,
        FW_LAT  = 3'd3,
        FW_WB   = 3'd4
    } fw_src_e;

endpackage

// File: rtl/fwd_port_sel.sv
// Single read-port forwarding priority mux.
// Picks the youngest in-flight producer of the requested register:
// EXE (non-load) > MEM > completing long-latency result > WB.
// Ports:
//   re, raddr                      - read enable / address of this port
//   exe_*, mem_*, wb_*             - pipeline stage results
//   lat_done, lat_done_waddr/wdata - long-latency completion this cycle
//   fw_en, fw_data                 - forward valid / data (0 when no hit)
//   load_hit                       - port matches a load still in EXE
module fwd_port_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int RADDR_W = RADDR_WIDTH,
    parameter int RDATA_W = RDATA_WIDTH
) (
    input  logic               re,
    input  logic [RADDR_W-1:0] raddr,
    input  logic [RADDR_W-1:0] exe_waddr,
    input  logic [RDATA_W-1:0] exe_wdata,
    input  logic               exe_we,
    input  logic               exe_is_load,
    input  logic [RADDR_W-1:0] mem_waddr,
    input  logic [RDATA_W-1:0] mem_wdata,
    input  logic               mem_we,
    input  logic               lat_done,
    input  logic [RADDR_W-1:0] lat_done_waddr,
    input  logic [RDATA_W-1:0] lat_done_wdata,
    input  logic [RADDR_W-1:0] wb_waddr,
    input  logic [RDATA_W-1:0] wb_wdata,
    input  logic               wb_we,
    output logic               fw_en,
    output logic [RDATA_W-1:0] fw_data,
    output logic               load_hit
);

    fw_src_e src;
    logic    active;
    logic    exe_match;

    assign active    = (re == READ_ENABLE) && (raddr != RADDR_W'(ZERO));
    assign exe_match = (exe_we == WRITE_ENABLE) && (exe_waddr == raddr);

    always_comb begin
        src      = FW_NONE;
        load_hit = 1'b0;
        if (active) begin
            load_hit = exe_match && exe_is_load;
            // A matching load has no data yet; fall through to older
            // stages (the stall covers the cycle anyway).
            if (exe_match && !exe_is_load) begin
                src = FW_EXE;
            end else if ((mem_we == WRITE_ENABLE) && (mem_waddr == raddr)) begin
                src = FW_MEM;
            end else if (lat_done && (lat_done_waddr == raddr)) begin
                src = FW_LAT;
            end else if ((wb_we == WRITE_ENABLE) && (wb_waddr == raddr)) begin
                src = FW_WB;
            end
        end
    end

    always_comb begin
        fw_en   = 1'b1;
        fw_data = '0;
        case (src)
            FW_EXE:  fw_data = exe_wdata;
            FW_MEM:  fw_data = mem_wdata;
            FW_LAT:  fw_data = lat_done_wdata;
            FW_WB:   fw_data = wb_wdata;
            default: fw_en   = 1'b0;
        endcase
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding and hazard unit.
// Forwards NUM_RPORTS operands from EXE/MEM/long-latency/WB, detects
// load-use hazards and RAW/WAW hazards against a per-register busy
// scoreboard of outstanding long-latency writes, drives stall_o and keeps
// saturating stall statistics plus a sticky long-latency timeout flag.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   raddr_i, re_i              - ID read addresses / enables (packed per port)
//   id_waddr_i, id_we_i        - ID destination (WAW check)
//   exe_*, mem_*, wb_*         - pipeline stage results
//   lat_issue_i, lat_waddr_i   - long-latency op leaving ID
//   lat_done_*                 - long-latency completion
//   fw_en_o, fw_data_o         - per-port forward valid / data
//   stall_o                    - combinational pipeline stall
//   stall_cnt_load_o/_lat_o    - saturating stall counters
//   timeout_o                  - sticky long-latency timeout
//
// state   | meaning
// FH_RUN  | no stall last cycle
// FH_LOAD | last cycle stalled on a load-use hazard
// FH_LAT  | stalling on a busy register; lat_run counts these cycles
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_RPORTS = 2,
    parameter int RADDR_W    = RADDR_WIDTH,
    parameter int RDATA_W    = RDATA_WIDTH,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RPORTS*RADDR_W-1:0] raddr_i,
    input  logic [NUM_RPORTS-1:0]         re_i,
    input  logic [RADDR_W-1:0]            id_waddr_i,
    input  logic                          id_we_i,
    input  logic [RADDR_W-1:0]            exe_waddr_i,
    input  logic [RDATA_W-1:0]            exe_wdata_i,
    input  logic                          exe_we_i,
    input  logic                          exe_is_load_i,
    input  logic [RADDR_W-1:0]            mem_waddr_i,
    input  logic [RDATA_W-1:0]            mem_wdata_i,
    input  logic                          mem_we_i,
    input  logic [RADDR_W-1:0]            wb_waddr_i,
    input  logic [RDATA_W-1:0]            wb_wdata_i,
    input  logic                          wb_we_i,
    input  logic                          lat_issue_i,
    input  logic [RADDR_W-1:0]            lat_waddr_i,
    input  logic                          lat_done_i,
    input  logic [RADDR_W-1:0]            lat_done_waddr_i,
    input  logic [RDATA_W-1:0]            lat_done_wdata_i,
    output logic [NUM_RPORTS-1:0]         fw_en_o,
    output logic [NUM_RPORTS*RDATA_W-1:0] fw_data_o,
    output logic                          stall_o,
    output logic [CNT_W-1:0]              stall_cnt_load_o,
    output logic [CNT_W-1:0]              stall_cnt_lat_o,
    output logic                          timeout_o
);

    localparam int REG_NUM = 2 ** RADDR_W;
    localparam int LRUN_W  = $clog2(TIMEOUT) + 1;

    logic [REG_NUM-1:0]    busy_q;
    logic [REG_NUM-1:0]    busy_d;
    logic [NUM_RPORTS-1:0] load_hit;
    logic [NUM_RPORTS-1:0] raw_hit;
    logic                  load_haz;
    logic                  lat_haz;
    logic                  waw_hit;
    logic                  busy_set;
    fh_state_e             state_q;
    fh_state_e             state_d;
    logic [LRUN_W-1:0]     lat_run_q;

    for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_port
        logic [RADDR_W-1:0] raddr_k;
        assign raddr_k = raddr_i[k*RADDR_W +: RADDR_W];

        fwd_port_sel #(
            .RADDR_W (RADDR_W),
            .RDATA_W (RDATA_W)
        ) u_sel (
            .re             (re_i[k]),
            .raddr          (raddr_k),
            .exe_waddr      (exe_waddr_i),
            .exe_wdata      (exe_wdata_i),
            .exe_we         (exe_we_i),
            .exe_is_load    (exe_is_load_i),
            .mem_waddr      (mem_waddr_i),
            .mem_wdata      (mem_wdata_i),
            .mem_we         (mem_we_i),
            .lat_done       (lat_done_i),
            .lat_done_waddr (lat_done_waddr_i),
            .lat_done_wdata (lat_done_wdata_i),
            .wb_waddr       (wb_waddr_i),
            .wb_wdata       (wb_wdata_i),
            .wb_we          (wb_we_i),
            .fw_en          (fw_en_o[k]),
            .fw_data        (fw_data_o[k*RDATA_W +: RDATA_W]),
            .load_hit       (load_hit[k])
        );

        // A result completing this cycle is bypassed, not stalled on.
        assign raw_hit[k] = re_i[k] && (raddr_k != RADDR_W'(ZERO)) && busy_q[raddr_k]
                            && !(lat_done_i && (lat_done_waddr_i == raddr_k));
    end

    assign waw_hit  = id_we_i && busy_q[id_waddr_i];
    assign load_haz = |load_hit;
    assign lat_haz  = (|raw_hit) || waw_hit;
    assign stall_o  = load_haz || lat_haz;

    // A stalled issue never leaves ID, so it must not mark its target busy.
    assign busy_set = lat_issue_i && (lat_waddr_i != RADDR_W'(ZERO)) && !stall_o;

    always_comb begin
        busy_d = busy_q;
        if (lat_done_i) busy_d[lat_done_waddr_i] = 1'b0;
        if (busy_set)   busy_d[lat_waddr_i]      = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FH_RUN: begin
                if (load_haz)     state_d = FH_LOAD;
                else if (lat_haz) state_d = FH_LAT;
            end
            FH_LOAD: state_d = lat_haz ? FH_LAT : FH_RUN;
            FH_LAT:  state_d = lat_haz ? FH_LAT : FH_RUN;
            default: state_d = FH_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q           <= '0;
            state_q          <= FH_RUN;
            stall_cnt_load_o <= '0;
            stall_cnt_lat_o  <= '0;
            lat_run_q        <= '0;
            timeout_o        <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            state_q <= state_d;
            if (load_haz && (stall_cnt_load_o != '1))
                stall_cnt_load_o <= stall_cnt_load_o + CNT_W'(1);
            if (lat_haz && !load_haz && (stall_cnt_lat_o != '1))
                stall_cnt_lat_o <= stall_cnt_lat_o + CNT_W'(1);
            if (state_q != FH_LAT) begin
                lat_run_q <= '0;
            end else begin
                // Hold at the terminal count rather than wrap.
                if (lat_run_q != LRUN_W'(TIMEOUT - 1))
                    lat_run_q <= lat_run_q + LRUN_W'(1);
                else
                    timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the ID-stage forwarding logic.
- Serves NUM_RPORTS source operands per cycle and forwards from EXE, MEM and WB in youngest-first order.
- Detects load-use hazards and tracks outstanding long-latency writes (DIV/MUL unit) in a per-register scoreboard.
- Drives the pipeline stall and keeps stall statistics. It sits between the ID stage, the pipeline registers and the hazard/ctrl logic.

Parameters:
- NUM_RPORTS, 2: number of ID read ports (1..4).
- RADDR_W, 5: register address width; REG_NUM = 2**RADDR_W.
- RDATA_W, 32: register data width.
- TIMEOUT, 64: consecutive long-latency stall cycles before the timeout flag sets.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- raddr_i  in  NUM_RPORTS*RADDR_W  ID read addresses; port k occupies bits [k*RADDR_W +: RADDR_W].
- re_i  in  NUM_RPORTS  ID read enables.
- id_waddr_i  in  RADDR_W  ID destination register.
- id_we_i  in  1  ID write enable.
- exe_waddr_i, exe_wdata_i, exe_we_i  in  RADDR_W/RDATA_W/1  EXE result.
- exe_is_load_i  in  1  the EXE instruction is a load (its data is not yet valid).
- mem_waddr_i, mem_wdata_i, mem_we_i  in  RADDR_W/RDATA_W/1  MEM result.
- wb_waddr_i, wb_wdata_i, wb_we_i  in  RADDR_W/RDATA_W/1  WB result.
- lat_issue_i  in  1  long-latency op leaves ID this cycle.
- lat_waddr_i  in  RADDR_W  its destination register.
- lat_done_i  in  1  long-latency result valid this cycle.
- lat_done_waddr_i  in  RADDR_W  destination of that result.
- lat_done_wdata_i  in  RDATA_W  the result data.
- fw_en_o  out  NUM_RPORTS  per-port forward valid.
- fw_data_o  out  NUM_RPORTS*RDATA_W  per-port forwarded data.
- stall_o  out  1  hold PC/IF/ID and insert a bubble into EXE.
- stall_cnt_load_o  out  CNT_W  saturating count of load-use stall cycles.
- stall_cnt_lat_o  out  CNT_W  saturating count of scoreboard stall cycles.
- timeout_o  out  1  sticky long-latency timeout flag.

Behaviour:
- Forward select, per port k, combinational:
  - If re_i[k]=0 or raddr=0: fw_en=0, data=0.
  - Otherwise priority is EXE (we & match & !load) > MEM > lat_done (match) > WB.
  - The first hit sets fw_en=1 with that source's data; no hit gives fw_en=0, data=0.
  - An EXE match with exe_is_load_i=1 does not forward.
- Load-use: any port with re, raddr≠0, exe_we, exe_is_load and a match raises load_haz.
- Scoreboard: busy[REG_NUM] register.
  - Set on lat_issue_i & lat_waddr≠0 & !stall_o.
  - Clear on lat_done_i. When set and clear hit the same register in the same cycle, set wins.
  - busy[0] is always 0. Reset value: all 0.
- lat_haz (RAW/WAW on a busy register):
  - RAW: any port with re, raddr≠0, busy[raddr]=1 and not (lat_done_i & lat_done_waddr==raddr). A result completing this cycle is bypassed instead of stalled.
  - WAW: id_we & busy[id_waddr].
- stall_o = load_haz | lat_haz, combinational, same cycle.
- FSM (registered; drives the counters and timeout only):
  - S_RUN -> S_LOAD when load_haz.
  - S_RUN -> S_LAT when lat_haz & !load_haz.
  - S_LOAD -> S_RUN, or -> S_LAT if lat_haz is now set.
  - S_LAT stays while lat_haz; otherwise -> S_RUN.
  - Reset state: S_RUN.
- Counters:
  - stall_cnt_load increments each cycle load_haz=1.
  - stall_cnt_lat increments each cycle lat_haz & !load_haz.
  - Both saturate at all-ones and reset to 0.
- Timeout:
  - lat_run counter clears outside S_LAT and increments in S_LAT.
  - When lat_run reaches TIMEOUT-1 while in S_LAT, timeout_o is set and stays set until reset.
- Reset mid-stall: rst_n low clears busy, FSM, counters and timeout asynchronously; stall_o drops immediately because busy=0.
- Outputs during reset: fw_en/fw_data follow the combinational rules above and are otherwise 0; stall_o=0 unless load_haz.

Decomposition:
- Shared defines carry RADDR_WIDTH, RDATA_WIDTH, ZERO, READ_ENABLE/WRITE_ENABLE, the FSM state encodings (FH_RUN/FH_LOAD/FH_LAT) and FW source encodings (FW_NONE/FW_EXE/FW_MEM/FW_LAT/FW_WB).
- One sub-module, fwd_port_sel: a single-port priority mux, instantiated NUM_RPORTS times via generate.
- Scoreboard, FSM and counters stay in the top.

Test Plan:
- exe_we=1, waddr=5, wdata=0xAAAA; mem writes x5=0xBBBB; port0 reads x5 -> fw_en[0]=1, data=0xAAAA, stall_o=0.
- Port1 reads x0 while exe writes x0=0x1234 -> fw_en[1]=0, data=0.
- exe_is_load=1, exe_waddr=7; port0 reads x7 -> stall_o=1 for one cycle, stall_cnt_load=1. Next cycle mem forwards x7 and stall_o=0.
- lat_issue x9; port1 reads x9 for 10 cycles, then lat_done x9=0xDEAD -> stall_o=1 for 10 cycles, then 0 with data=0xDEAD on the done cycle; stall_cnt_lat=10; busy[9]=0 afterwards.
- lat_issue x3 with no lat_done and a continuous x3 read, TIMEOUT=64 -> timeout_o rises on the 64th S_LAT cycle and stays high. Assert rst_n=0 mid-stall -> everything clears asynchronously.
- Same-cycle lat_issue x4 and lat_done x4 -> busy[4]=1 next cycle. id_we with id_waddr=4 -> stall_o=1 (WAW).
